// File: rtl/stream_crop_pack_if.sv
// Handshake/bus bundle for stream_crop_pack: config writes, filtered pixel
// input and the packed ready/valid output with its overflow flag.
interface stream_crop_pack_if #(
   parameter int CFG_DWIDTH = 32,
   parameter int CFG_AWIDTH = 5,
   parameter int IMG_WIDTH  = 16
);
   logic [CFG_DWIDTH-1:0]  cfg_data;
   logic [CFG_AWIDTH-1:0]  cfg_addr;
   logic                   cfg_valid;
   logic [IMG_WIDTH-1:0]   result;
   logic                   result_val;
   logic [2*IMG_WIDTH-1:0] out_data;
   logic                   out_last;
   logic                   out_valid;
   logic                   out_ready;
   logic                   overflow;

   modport master (
      output cfg_data, cfg_addr, cfg_valid, result, result_val, out_ready,
      input  out_data, out_last, out_valid, overflow
   );

   modport slave (
      input  cfg_data, cfg_addr, cfg_valid, result, result_val, out_ready,
      output out_data, out_last, out_valid, overflow
   );
endinterface

// File: rtl/stream_crop_pack.sv
// Crops a raster pixel stream to a configurable window, packs kept pixels in
// pairs and queues the words in a first-word-fall-through output FIFO.
module stream_crop_pack #(
   parameter int CFG_DWIDTH  = 32,
   parameter int CFG_AWIDTH  = 5,
   parameter int IMG_WIDTH   = 16,
   parameter int FIFO_AWIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   stream_crop_pack_if.slave bus
);
   localparam int DEPTH = 1 << FIFO_AWIDTH;
   localparam int WW    = 2 * IMG_WIDTH;

   logic [15:0] width_q;
   logic [7:0]  top_q, left_q, right_q;
   logic [15:0] col_q;
   logic [7:0]  row_q;

   logic                 pend_vld_q;
   logic [IMG_WIDTH-1:0] pend_q;
   logic                 st_vld_q;
   logic [WW-1:0]        st_data_q;
   logic                 st_last_q;

   logic [WW:0]            mem [DEPTH];
   logic [FIFO_AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AWIDTH:0]   count_q;
   logic                   overflow_q;

   logic        cfg_hit, cfg_is_width;
   logic [16:0] lr_sum;
   logic        crop_ok;
   logic [15:0] right_edge;
   logic        keep, row_end_keep, col_wrap;
   logic        empty, full, push, pop, drop;
   logic        unused_cfg_bits;

   assign unused_cfg_bits = ^bus.cfg_data[CFG_DWIDTH-1:24];

   assign cfg_is_width = (bus.cfg_addr == CFG_AWIDTH'(1));
   assign cfg_hit      = bus.cfg_valid && (cfg_is_width || bus.cfg_addr == CFG_AWIDTH'(4));

   // A window with no columns left (or no row width) keeps nothing.
   assign lr_sum       = {9'd0, left_q} + {9'd0, right_q};
   assign crop_ok      = (width_q != 16'd0) && (lr_sum < {1'b0, width_q});
   assign right_edge   = width_q - {8'd0, right_q};
   assign keep         = bus.result_val && !cfg_hit && crop_ok && (row_q >= top_q) &&
                         (col_q >= {8'd0, left_q}) && (col_q < right_edge);
   assign row_end_keep = (col_q == right_edge - 16'd1);
   assign col_wrap     = (col_q == width_q - 16'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         width_q    <= '0;
         top_q      <= '0;
         left_q     <= '0;
         right_q    <= '0;
         col_q      <= '0;
         row_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_q     <= '0;
         st_vld_q   <= 1'b0;
         st_data_q  <= '0;
         st_last_q  <= 1'b0;
      end else begin
         st_vld_q <= 1'b0;
         if (cfg_hit) begin
            if (cfg_is_width) begin
               width_q <= bus.cfg_data[15:0];
            end else begin
               top_q   <= bus.cfg_data[23:16];
               left_q  <= bus.cfg_data[15:8];
               right_q <= bus.cfg_data[7:0];
            end
            col_q      <= '0;
            row_q      <= '0;
            pend_vld_q <= 1'b0;
         end else if (bus.result_val) begin
            if (col_wrap) begin
               col_q <= '0;
               if (row_q != 8'hFF) row_q <= row_q + 8'd1;
            end else begin
               col_q <= col_q + 16'd1;
            end
            // The kept span is contiguous, so its right edge closes the row.
            if (keep) begin
               if (pend_vld_q) begin
                  st_vld_q   <= 1'b1;
                  st_data_q  <= {bus.result, pend_q};
                  st_last_q  <= row_end_keep;
                  pend_vld_q <= 1'b0;
               end else if (row_end_keep) begin
                  st_vld_q  <= 1'b1;
                  st_data_q <= {{IMG_WIDTH{1'b0}}, bus.result};
                  st_last_q <= 1'b1;
               end else begin
                  pend_q     <= bus.result;
                  pend_vld_q <= 1'b1;
               end
            end
         end
      end
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == (FIFO_AWIDTH+1)'(DEPTH));
   assign pop   = !empty && bus.out_ready;
   // A read in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = st_vld_q && (!full || pop);
   assign drop  = st_vld_q && full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {st_last_q, st_data_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_AWIDTH'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AWIDTH'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (FIFO_AWIDTH+1)'(1);
            2'b01:   count_q <= count_q - (FIFO_AWIDTH+1)'(1);
            default: count_q <= count_q;
         endcase
         if (drop) overflow_q <= 1'b1;
      end
   end

   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? '0 : mem[rd_ptr_q][WW-1:0];
   assign bus.out_last  = !empty && mem[rd_ptr_q][WW];
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_stream_crop_pack.sv
// Randomized and directed bench for stream_crop_pack; words are scored
// against a window/packing model built from row/column arithmetic.
module tb_stream_crop_pack;
   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stream_crop_pack_if bus ();
   stream_crop_pack dut (.clk(clk), .rst(rst), .bus(bus));

   int    checks = 0;
   int    errors = 0;
   word_t exp_q[$];

   int m_w = 0, m_t = 0, m_l = 0, m_r = 0, m_idx = 0;
   int row_kept[$];
   bit rand_ready = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void push_exp(int hi, int lo, bit last);
      word_t w;
      w.data = {hi[15:0], lo[15:0]};
      w.last = last;
      exp_q.push_back(w);
   endfunction

   function automatic void model_cfg(int addr, int data);
      if (addr == 1 || addr == 4) begin
         if (addr == 1) m_w = data & 32'hFFFF;
         else begin
            m_t = (data >> 16) & 8'hFF;
            m_l = (data >> 8) & 8'hFF;
            m_r = data & 8'hFF;
         end
         m_idx = 0;
         row_kept.delete();
      end
   endfunction

   // Position comes from the pixel index since the last config write.
   function automatic void model_pix(int v);
      int col, row, k, n, prev;
      if (m_w > 0 && (m_l + m_r) < m_w) begin
         col = m_idx % m_w;
         row = m_idx / m_w;
         if (row > 255) row = 255;
         if (col == 0) row_kept.delete();
         if (row >= m_t && col >= m_l && col < m_w - m_r) begin
            row_kept.push_back(v);
            k = m_w - m_l - m_r;
            n = row_kept.size();
            if (n % 2 == 0) begin
               prev = row_kept[n-2];
               push_exp(v, prev, n == k);
            end else if (n == k) begin
               push_exp(0, v, 1'b1);
            end
         end
      end
      m_idx++;
   endfunction

   task automatic tick();
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(int addr, int data, bit with_pix = 1'b0, int pix = 0);
      bus.cfg_addr   = 5'(addr);
      bus.cfg_data   = 32'(data);
      bus.cfg_valid  = 1'b1;
      bus.result_val = with_pix;
      bus.result     = 16'(pix);
      tick();
      bus.cfg_valid  = 1'b0;
      bus.result_val = 1'b0;
      model_cfg(addr, data);
   endtask

   task automatic send_pix(int v, bit use_model);
      bus.result     = 16'(v);
      bus.result_val = 1'b1;
      tick();
      bus.result_val = 1'b0;
      if (use_model) model_pix(v);
   endtask

   task automatic wait_drain(string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_idle"}, 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      model_cfg(1, 0);
      model_cfg(4, 0);
   endtask

   // Scoreboard: every transfer is popped in order; stalled words must hold.
   initial begin
      logic        stall;
      logic [32:0] held;
      word_t       w;
      stall = 1'b0;
      held  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("hold_valid", 64'(bus.out_valid), 64'd1);
               chk("hold_word", 64'({bus.out_last, bus.out_data}), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_word", 64'(bus.out_valid), 64'd0);
               end else begin
                  w = exp_q.pop_front();
                  chk("word", 64'({bus.out_last, bus.out_data}), 64'({w.last, w.data}));
               end
            end
            stall = bus.out_valid && !bus.out_ready;
            held  = {bus.out_last, bus.out_data};
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

   initial begin
      int w, t, l, r, n, pv;
      rst            = 1'b1;
      bus.cfg_data   = '0;
      bus.cfg_addr   = '0;
      bus.cfg_valid  = 1'b0;
      bus.result     = '0;
      bus.result_val = 1'b0;
      bus.out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_last", 64'(bus.out_last), 64'd0);
      chk("rst_overflow", 64'(bus.overflow), 64'd0);
      chk("rst_data", 64'(bus.out_data), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic pack with first-word latency
      cfg_write(1, 10);
      cfg_write(4, 0);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) push_exp(2*i, 2*i-1, i == 5);
      send_pix(1, 0);
      send_pix(2, 0);
      @(negedge clk);
      chk("lat_t1_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("lat_t2_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      for (int i = 3; i <= 10; i++) send_pix(i, 0);
      wait_drain("basic");

      // Odd crop: row 0 dropped, unpaired tail closes row 1
      cfg_write(1, 10);
      cfg_write(4, 32'h010102);
      push_exp(13, 12, 0);
      push_exp(15, 14, 0);
      push_exp(17, 16, 0);
      push_exp(0, 18, 1);
      for (int i = 1; i <= 20; i++) send_pix(i, 0);
      wait_drain("crop");

      // Backpressure to overflow, then ordered drain
      cfg_write(1, 8);
      cfg_write(4, 0);
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 32; i++) send_pix(i, 0);
      tick();
      tick();
      chk("bp_ovf_at16", 64'(bus.overflow), 64'd0);
      for (int i = 33; i <= 40; i++) send_pix(i, 0);
      tick();
      tick();
      chk("bp_ovf_after17", 64'(bus.overflow), 64'd1);
      chk("bp_head", 64'({bus.out_last, bus.out_data}), 64'({1'b0, 16'd2, 16'd1}));
      for (int i = 1; i <= 16; i++) push_exp(2*i, 2*i-1, (i % 4) == 0);
      bus.out_ready = 1'b1;
      wait_drain("bp");
      chk("bp_ovf_sticky", 64'(bus.overflow), 64'd1);
      pulse_rst();
      chk("rst_clears_ovf", 64'(bus.overflow), 64'd0);

      // Full FIFO with a read in the same cycle as the write
      cfg_write(1, 1);
      cfg_write(4, 0);
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 46; i++) begin
         if (i == 18) bus.out_ready = 1'b1;
         push_exp(0, i, 1);
         send_pix(i, 0);
      end
      wait_drain("full_rd");
      chk("full_rd_ovf", 64'(bus.overflow), 64'd0);

      // Degenerate windows
      cfg_write(1, 4);
      cfg_write(4, 32'h0202);
      for (int i = 1; i <= 12; i++) send_pix(i, 0);
      wait_drain("degen_lr");
      cfg_write(1, 0);
      cfg_write(4, 0);
      for (int i = 1; i <= 12; i++) send_pix(i, 0);
      wait_drain("degen_w0");

      // Config mid-row discards the pending half-word
      cfg_write(1, 10);
      cfg_write(4, 0);
      push_exp(2, 1, 0);
      for (int i = 1; i <= 3; i++) send_pix(i, 0);
      cfg_write(4, 0);
      for (int i = 2; i <= 6; i++) push_exp(2*i+1, 2*i, i == 6);
      for (int i = 4; i <= 13; i++) send_pix(i, 0);
      wait_drain("midcfg");
      // Config beats a simultaneous pixel
      cfg_write(4, 0, 1'b1, 99);
      for (int i = 1; i <= 5; i++) push_exp(2*i, 2*i-1, i == 5);
      for (int i = 1; i <= 10; i++) send_pix(i, 0);
      wait_drain("cfg_pix");

      // Reset during a stalled handshake abandons everything
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_pix(i, 0);
      chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      send_pix(6, 0);
      pulse_rst();
      @(negedge clk);
      chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("post_rst_data", 64'(bus.out_data), 64'd0);
      @(posedge clk);
      #1;
      tick();
      tick();
      chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b1;
      cfg_write(1, 10);
      push_exp(2, 1, 0);
      send_pix(1, 0);
      send_pix(2, 0);
      wait_drain("post_rst");

      // Randomized windows, gaps, ignored addresses and backpressure
      for (int it = 0; it < 30; it++) begin
         w = $urandom_range(0, 12);
         t = $urandom_range(0, 2);
         l = $urandom_range(0, 4);
         r = $urandom_range(0, 4);
         rand_ready = ($urandom_range(0, 1) == 1);
         n = rand_ready ? $urandom_range(0, 16) : $urandom_range(0, 40);
         bus.out_ready = 1'b1;
         cfg_write(1, w);
         cfg_write(4, (t << 16) | (l << 8) | r);
         for (int i = 0; i < n; i++) begin
            pv = $urandom_range(1, 16'hFFFF);
            case ($urandom_range(0, 9))
               0: tick();
               1: cfg_write($urandom_range(5, 31), $urandom);
               2: cfg_write(0, $urandom);
               default: ;
            endcase
            send_pix(pv, 1);
         end
         rand_ready = 0;
         bus.out_ready = 1'b1;
         wait_drain("rand");
      end
      chk("rand_ovf", 64'(bus.overflow), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_crop_pack.md
STREAM_CROP_PACK -- requirements
Module: stream_crop_pack

Interface
REQ-001 Parameters SHALL be:
  - CFG_DWIDTH, default 32, config data width.
  - CFG_AWIDTH, default 5, config address width.
  - IMG_WIDTH, default 16, pixel width.
  - FIFO_AWIDTH, default 4, output FIFO address width (depth 2**FIFO_AWIDTH words).
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk  in  1  single clock, all logic on its rising edge.
  - rst  in  1  synchronous, active-high reset.
  - cfg_data  in  CFG_DWIDTH  config write data.
  - cfg_addr  in  CFG_AWIDTH  config register address.
  - cfg_valid  in  1  config write strobe.
  - result  in  IMG_WIDTH  filtered pixel from the filter stage.
  - result_val  in  1  pixel valid; no backpressure exists on this input.
  - out_data  out  2*IMG_WIDTH  packed pixel pair.
  - out_last  out  1  word is the final word of a row.
  - out_valid  out  1  out_data/out_last valid.
  - out_ready  in  1  consumer accepts the word.
  - overflow  out  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-003 Config writes (cfg_valid=1) SHALL decode as follows; any other address is ignored:
  - addr 1: row width W = cfg_data[15:0].
  - addr 4: top T = cfg_data[23:16], left L = cfg_data[15:8], right R = cfg_data[7:0].
REQ-004 Any decoded config write SHALL clear the column counter, row counter and pending half-word in the same cycle; FIFO contents SHALL be preserved.
REQ-005 Each result_val=1 cycle SHALL advance the column counter. At col = W-1, col SHALL wrap to 0 and row SHALL increment, saturating at 255.
REQ-006 A pixel SHALL be kept iff row >= T, col >= L and col < W-R, all compares unsigned. If L+R >= W or W = 0, no pixel is kept.
REQ-007 Packing: the first kept pixel of a pair SHALL go to out_data[IMG_WIDTH-1:0] and the second to the upper half. A completed pair SHALL form one FIFO word.
REQ-008 If the last kept pixel of a row is unpaired, it SHALL be emitted as a word with the upper half zero. The last word of each row with at least one kept pixel SHALL carry out_last=1; all other words carry out_last=0.
REQ-009 Latency: the word completed by the input at cycle t SHALL be written to the FIFO at the edge ending cycle t+1. out_valid SHALL be high in cycle t+2 if the FIFO was empty.
REQ-010 FIFO SHALL be first-word-fall-through with ready/valid handshake:
  - A word transfers when out_valid and out_ready are both high.
  - out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-011 Simultaneous FIFO write and read SHALL be allowed in every state. When full with out_ready=1, the write SHALL succeed and overflow SHALL not set.
REQ-012 A write to a full FIFO without a read SHALL drop the incoming word and set overflow=1. overflow SHALL stay set until reset.
REQ-013 A config write coinciding with result_val=1 SHALL take priority: that pixel is discarded and counters restart at 0.
REQ-014 Count of FIFO occupancy SHALL use FIFO_AWIDTH+1 bits; empty and full SHALL be derived from it. Pointers SHALL wrap modulo depth.

Reset
REQ-015 While rst=1 at a clock edge:
  - out_valid=0, out_last=0, overflow=0.
  - FIFO emptied, counters and pending half-word cleared.
  - W=0, T=0, L=0, R=0.
REQ-016 out_data reset value SHALL be 0.
REQ-017 Reset asserted mid-row or mid-handshake SHALL abandon all data, with no partial word emitted afterward.
REQ-018 The first cycle after rst falls SHALL accept config writes and pixels.

Verification
REQ-019 Basic pack: W=10, T=L=R=0, pixels 1..10 with out_ready=1 -> five words {2,1},{4,3},{6,5},{8,7},{10,9}. out_last=1 on {10,9} only. First out_valid 2 cycles after pixel 2.
REQ-020 Crop odd: W=10, L=1, R=2, T=1, 20 pixels 1..20:
  - row 0 dropped entirely.
  - Row 1 yields {13,12},{15,14},{17,16},{0,18}, with out_last=1 on {0,18}.
REQ-021 Backpressure: W=8, out_ready=0 for 40 pixels, FIFO_AWIDTH=4 -> 16 words stored, overflow=1 after the 17th word. On release, words 1..16 drain in order with data held stable while stalled.
REQ-022 Full plus simultaneous read: FIFO full, out_ready=1 held, pixels stream at full rate -> no drops and overflow stays 0.
REQ-023 Degenerate: W=4, L=2, R=2 -> no words ever emitted. Separately, W=0 -> no words emitted.
REQ-024 Mid-operation events:
  - Config write (addr 4) after 3 pixels of a W=10 row -> pending half-word discarded and the next pixel is treated as col 0.
  - rst pulsed while out_valid=1 -> out_valid=0 the next cycle and the FIFO is empty.
